// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
// Hazard-to-control paths are combinational; wait timer, stall counter and timeout flag are registered.
module pipe_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rd_e,
   input  logic             mem_read_e,
   input  logic             redirect_e,
   input  logic             imiss_f,
   input  logic             imem_ready,
   input  logic             dmiss_m,
   input  logic             dmem_ready,
   output logic             en_f,
   output logic             en_d,
   output logic             en_e,
   output logic             en_m,
   output logic             en_w,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             imiss_abort,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err_timeout
);
   // state | meaning
   // RUN   | pipeline flowing, hazards resolved within the cycle
   // IWAIT | fetch miss outstanding, D receives bubbles
   // DWAIT | data miss outstanding, F..M frozen, W receives bubbles

   localparam int              WC_W   = $clog2(TIMEOUT);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, IWAIT, DWAIT} state_t;

   state_t          state, state_nxt;
   logic            ipend, idone, ipend_nxt, idone_nxt;
   logic            renew;
   logic            lu;
   logic [WC_W-1:0] wait_cnt;

   assign lu = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

   always_comb begin
      en_f        = 1'b1;
      en_d        = 1'b1;
      en_e        = 1'b1;
      en_m        = 1'b1;
      en_w        = 1'b1;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_w     = 1'b0;
      imiss_abort = 1'b0;
      state_nxt   = state;
      ipend_nxt   = ipend;
      idone_nxt   = idone;
      renew       = 1'b0;
      unique case (state)
         RUN: begin
            if (dmiss_m) begin
               {en_f, en_d, en_e, en_m} = 4'b0000;
               flush_w   = 1'b1;
               state_nxt = DWAIT;
               ipend_nxt = 1'b0;
               idone_nxt = 1'b0;
            end else if (redirect_e) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (lu) begin
               en_f    = 1'b0;
               en_d    = 1'b0;
               flush_e = 1'b1;
            end else if (imiss_f) begin
               en_f      = 1'b0;
               flush_d   = 1'b1;
               state_nxt = IWAIT;
            end
         end
         IWAIT: begin
            en_f    = 1'b0;
            flush_d = 1'b1;
            if (dmiss_m) begin
               {en_d, en_e, en_m} = 3'b000;
               flush_w   = 1'b1;
               state_nxt = DWAIT;
               ipend_nxt = 1'b1;
               idone_nxt = imem_ready;
            end else if (redirect_e) begin
               en_f        = 1'b1;
               flush_e     = 1'b1;
               imiss_abort = 1'b1;
               state_nxt   = RUN;
            end else if (imem_ready) begin
               en_f      = !lu;
               en_d      = !lu;
               flush_e   = lu;
               flush_d   = 1'b0;
               state_nxt = RUN;
            end else if (lu) begin
               en_d    = 1'b0;
               flush_e = 1'b1;
            end
         end
         DWAIT: begin
            {en_f, en_d, en_e, en_m} = 4'b0000;
            flush_w = 1'b1;
            if (ipend && imem_ready) idone_nxt = 1'b1;
            // a fresh miss arriving with the fill restarts the wait
            if (dmem_ready && dmiss_m) begin
               renew = 1'b1;
            end else if (dmem_ready) begin
               {en_d, en_e, en_m} = 3'b111;
               flush_w = 1'b0;
               if (ipend && !idone && !imem_ready) begin
                  flush_d   = 1'b1;
                  state_nxt = IWAIT;
               end else begin
                  en_f      = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         default: state_nxt = RUN;
      endcase
      if (reset) begin
         {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
         {flush_d, flush_e, flush_w}    = 3'b111;
         imiss_abort                    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         ipend       <= 1'b0;
         idone       <= 1'b0;
         wait_cnt    <= '0;
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         ipend <= ipend_nxt;
         idone <= idone_nxt;
         if ((state_nxt != state) || renew)
            wait_cnt <= '0;
         else if ((state != RUN) && (wait_cnt != WC_MAX))
            wait_cnt <= wait_cnt + 1'b1;
         if ((state != RUN) && (state_nxt == state) && !renew && (wait_cnt == WC_MAX))
            err_timeout <= 1'b1;
         if (!en_f && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, corner-case sequences and a random run against a reference model.
// Two instances share stimulus: a wide one and a small one (CNT_W=3, TIMEOUT=4) for saturation/timeout.
module tb_pipe_ctrl;
   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic mr, redir, imiss, iready, dmiss, dready;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] out;
      int         sc;
   } vec_t;

   localparam int FLOW = 0, FETCH = 1, DATA = 2;
   localparam int TA = 16, TB = 4;

   logic clk = 1'b0, reset = 1'b1;
   logic [4:0] rs1_d, rs2_d, rd_e;
   logic mem_read_e, redirect_e, imiss_f, imem_ready, dmiss_m, dmem_ready;
   logic en_f_a, en_d_a, en_e_a, en_m_a, en_w_a, flush_d_a, flush_e_a, flush_w_a, abort_a, err_a_o;
   logic en_f_b, en_d_b, en_e_b, en_m_b, en_w_b, flush_d_b, flush_e_b, flush_w_b, abort_b, err_b_o;
   logic [7:0] stall_cnt_a;
   logic [2:0] stall_cnt_b;
   logic [8:0] outs_a, outs_b, obs_out, exp_out;

   int errors = 0, checks = 0;
   int mode, entry, edge_no, sc_a, sc_b, nx_mode;
   bit m_ipend, m_idone, err_a, err_b, nx_ipend, nx_idone, nx_restart;

   always #5 clk = ~clk;

   assign outs_a = {en_f_a, en_d_a, en_e_a, en_m_a, en_w_a, flush_d_a, flush_e_a, flush_w_a, abort_a};
   assign outs_b = {en_f_b, en_d_b, en_e_b, en_m_b, en_w_b, flush_d_b, flush_e_b, flush_w_b, abort_b};

   pipe_ctrl #(.CNT_W(8), .TIMEOUT(TA)) dut_a (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
      .mem_read_e(mem_read_e), .redirect_e(redirect_e), .imiss_f(imiss_f),
      .imem_ready(imem_ready), .dmiss_m(dmiss_m), .dmem_ready(dmem_ready),
      .en_f(en_f_a), .en_d(en_d_a), .en_e(en_e_a), .en_m(en_m_a), .en_w(en_w_a),
      .flush_d(flush_d_a), .flush_e(flush_e_a), .flush_w(flush_w_a),
      .imiss_abort(abort_a), .stall_cnt(stall_cnt_a), .err_timeout(err_a_o));

   pipe_ctrl #(.CNT_W(3), .TIMEOUT(TB)) dut_b (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
      .mem_read_e(mem_read_e), .redirect_e(redirect_e), .imiss_f(imiss_f),
      .imem_ready(imem_ready), .dmiss_m(dmiss_m), .dmem_ready(dmem_ready),
      .en_f(en_f_b), .en_d(en_d_b), .en_e(en_e_b), .en_m(en_m_b), .en_w(en_w_b),
      .flush_d(flush_d_b), .flush_e(flush_e_b), .flush_w(flush_w_b),
      .imiss_abort(abort_b), .stall_cnt(stall_cnt_b), .err_timeout(err_b_o));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic mr, input logic redir, input logic imiss,
                              input logic iready, input logic dmiss, input logic dready);
      in_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.redir = redir;
      v.imiss = imiss; v.iready = iready; v.dmiss = dmiss; v.dready = dready;
      return v;
   endfunction

   task automatic apply(input in_t v);
      {rs1_d, rs2_d, rd_e, mem_read_e, redirect_e, imiss_f, imem_ready, dmiss_m, dmem_ready} = v;
   endtask

   task automatic model_reset();
      mode = FLOW; m_ipend = 0; m_idone = 0; err_a = 0; err_b = 0;
      sc_a = 0; sc_b = 0; entry = 0; edge_no = 0;
   endtask

   // Expected control outputs for the present inputs, plus what the next edge should do.
   task automatic model_comb();
      bit lu, ef, ed, ee, em, ew, fd, fe, fw, ab;
      lu = mem_read_e && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
      {ef, ed, ee, em, ew} = 5'b11111;
      {fd, fe, fw, ab} = 4'b0000;
      nx_mode = mode; nx_ipend = m_ipend; nx_idone = m_idone; nx_restart = 0;
      if (mode == FLOW) begin
         if (dmiss_m) begin
            {ef, ed, ee, em} = 4'b0000; fw = 1; nx_mode = DATA; nx_ipend = 0; nx_idone = 0;
         end else if (redirect_e) begin
            fd = 1; fe = 1;
         end else if (lu) begin
            ef = 0; ed = 0; fe = 1;
         end else if (imiss_f) begin
            ef = 0; fd = 1; nx_mode = FETCH;
         end
      end else if (mode == FETCH) begin
         ef = 0; fd = 1;
         if (dmiss_m) begin
            {ed, ee, em} = 3'b000; fw = 1; nx_mode = DATA; nx_ipend = 1; nx_idone = imem_ready;
         end else if (redirect_e) begin
            ef = 1; fe = 1; ab = 1; nx_mode = FLOW;
         end else if (imem_ready) begin
            ef = !lu; ed = !lu; fe = lu; fd = 0; nx_mode = FLOW;
         end else if (lu) begin
            ed = 0; fe = 1;
         end
      end else begin
         {ef, ed, ee, em} = 4'b0000; fw = 1;
         if (m_ipend && imem_ready) nx_idone = 1;
         if (dmem_ready && dmiss_m) nx_restart = 1;
         else if (dmem_ready) begin
            {ed, ee, em} = 3'b111; fw = 0;
            if (m_ipend && !m_idone && !imem_ready) begin
               fd = 1; nx_mode = FETCH;
            end else begin
               ef = 1; nx_mode = FLOW;
            end
         end
      end
      exp_out = {ef, ed, ee, em, ew, fd, fe, fw, ab};
   endtask

   // Timeout is judged by distance (in edges) from the edge that started the current wait.
   task automatic model_edge();
      bit stay;
      stay = (nx_mode == mode) && !nx_restart;
      if (mode != FLOW && stay) begin
         if (edge_no - entry >= TB) err_b = 1;
         if (edge_no - entry >= TA) err_a = 1;
      end
      if (!stay) entry = edge_no;
      if (!exp_out[8]) begin
         if (sc_a < 255) sc_a++;
         if (sc_b < 7) sc_b++;
      end
      mode = nx_mode; m_ipend = nx_ipend; m_idone = nx_idone;
      edge_no++;
   endtask

   // One cycle; entered and left at a falling edge.
   task automatic run(input in_t v);
      apply(v);
      #1;
      model_comb();
      obs_out = outs_a;
      chk("outs_a", outs_a, exp_out);
      chk("outs_b", outs_b, exp_out);
      @(posedge clk);
      model_edge();
      #1;
      chk("stall_a", stall_cnt_a, sc_a);
      chk("stall_b", stall_cnt_b, sc_b);
      chk("err_a", err_a_o, err_a);
      chk("err_b", err_b_o, err_b);
      @(negedge clk);
   endtask

   task automatic do_reset();
      apply('0);
      reset = 1'b1;
      #1;
      chk("rst_outs_a", outs_a, 9'b00000_111_0);
      chk("rst_outs_b", outs_b, 9'b00000_111_0);
      chk("rst_stall", {stall_cnt_a, stall_cnt_b}, 0);
      chk("rst_err", {err_a_o, err_b_o}, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   vec_t tbl[11];
   in_t idle;

   initial begin
      idle = '0;
      //              rs1 rs2 rd  mr rdr imf ir dm dr         out (en fdmw, fl dew, ab)  sc
      tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 9'b11111_000_0, 0};
      tbl[1]  = '{mk(1, 5, 5, 1, 0, 0, 0, 0, 0), 9'b00111_010_0, 1};
      tbl[2]  = '{mk(0, 5, 0, 1, 0, 0, 0, 0, 0), 9'b11111_000_0, 0};
      tbl[3]  = '{mk(7, 2, 7, 1, 0, 0, 0, 0, 0), 9'b00111_010_0, 1};
      tbl[4]  = '{mk(7, 7, 7, 0, 0, 0, 0, 0, 0), 9'b11111_000_0, 0};
      tbl[5]  = '{mk(3, 0, 3, 1, 1, 1, 0, 0, 0), 9'b11111_110_0, 0};
      tbl[6]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 9'b01111_100_0, 1};
      tbl[7]  = '{mk(4, 4, 4, 1, 1, 0, 0, 1, 0), 9'b00001_001_0, 1};
      tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 9'b11111_000_0, 0};
      tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 9'b11111_000_0, 0};
      tbl[10] = '{mk(9, 1, 9, 1, 0, 1, 0, 0, 0), 9'b00111_010_0, 1};

      apply('0);
      @(negedge clk);
      foreach (tbl[i]) begin
         do_reset();
         run(tbl[i].in);
         chk($sformatf("tbl%0d_out", i), obs_out, tbl[i].out);
         chk($sformatf("tbl%0d_stall", i), stall_cnt_a, tbl[i].sc);
      end

      // reset while deep in a data wait
      do_reset();
      run(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 7; k++) run(idle);
      do_reset();
      run(idle);
      chk("post_rst_out", obs_out, 9'b11111_000_0);
      chk("post_rst_stall", stall_cnt_a, 0);
      chk("post_rst_err", {err_a_o, err_b_o}, 0);

      // fetch miss, then data miss; fetch resolves inside the data wait
      do_reset();
      run(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(idle);
      run(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      run(idle);
      run(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 0; k < 3; k++) run(idle);
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      chk("idone_exit", obs_out, 9'b11111_000_0);
      run(idle);
      chk("idone_run", obs_out, 9'b11111_000_0);

      // same, fetch still outstanding when the data fill arrives
      do_reset();
      run(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(idle);
      run(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 4; k++) run(idle);
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      chk("dwait_to_iwait", obs_out, 9'b01111_100_0);
      run(idle);
      chk("iwait_hold", obs_out, 9'b01111_100_0);
      run(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      chk("iwait_exit", obs_out, 9'b11111_000_0);

      // redirect while waiting on fetch
      do_reset();
      run(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(idle);
      chk("iwait_idle", obs_out, 9'b01111_100_0);
      run(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      chk("abort_pulse", obs_out, 9'b11111_110_1);
      run(idle);
      chk("abort_once", obs_out, 9'b11111_000_0);

      // data miss held forever: timeout and stall saturation
      do_reset();
      for (int k = 0; k < 20; k++) begin
         run(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
         chk($sformatf("tmo_b_e%0d", k), err_b_o, (k >= TB) ? 1 : 0);
         chk($sformatf("tmo_a_e%0d", k), err_a_o, (k >= TA) ? 1 : 0);
         chk($sformatf("sat_b_e%0d", k), stall_cnt_b, (k + 1 > 7) ? 7 : k + 1);
      end

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         in_t v;
         v.rs1    = 5'($urandom_range(0, 3));
         v.rs2    = 5'($urandom_range(0, 3));
         v.rd     = 5'($urandom_range(0, 3));
         v.mr     = ($urandom_range(0, 2) == 0);
         v.redir  = ($urandom_range(0, 7) == 0);
         v.imiss  = ($urandom_range(0, 5) == 0);
         v.iready = ($urandom_range(0, 3) == 0);
         v.dmiss  = ($urandom_range(0, 9) == 0);
         v.dready = ($urandom_range(0, 3) == 0);
         run(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
